// File: rtl/etapa1_hs_pkg.sv
// Shared definitions for the divider front stage: default widths, FSM encodings
// and the layout of the packed pre-conditioned operand entry.
package etapa1_hs_pkg;

  localparam int DV_W_DEF = 16;
  localparam int DD_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Entry layout, LSB first: flags, then |dividend|, then |divisor| on top.
  localparam int OFF_OVF    = 0;
  localparam int OFF_NOCERO = 1;
  localparam int OFF_NEGQ   = 2;
  localparam int OFF_NEGDD  = 3;
  localparam int OFF_NEGDV  = 4;
  localparam int FLAG_W     = 5;
  localparam int OFF_DDMAG  = FLAG_W;

  function automatic int off_dvmag(input int dd_w);
    return FLAG_W + dd_w;
  endfunction

  function automatic int entry_w(input int dv_w, input int dd_w);
    return FLAG_W + dd_w + dv_w;
  endfunction

endpackage

// File: rtl/div_precond.sv
// Combinational operand conditioning: magnitudes, sign bookkeeping,
// divide-by-zero and quotient-overflow detection, packed into one entry word.
module div_precond
  import etapa1_hs_pkg::*;
#(
  parameter int DV_W = DV_W_DEF,
  parameter int DD_W = DD_W_DEF
) (
  input  logic                              sgn,
  input  logic [DV_W-1:0]                   divisor,
  input  logic [DD_W-1:0]                   dividend,
  output logic [entry_w(DV_W, DD_W)-1:0]    entry
);

  localparam int Q_W = DD_W - DV_W;

  logic            neg_dv;
  logic            neg_dd;
  logic            no_cero;
  logic            neg_q;
  logic            ovf;
  logic [DV_W-1:0] dv_mag;
  logic [DD_W-1:0] dd_mag;

  always_comb begin
    neg_dv  = sgn & divisor[DV_W-1];
    neg_dd  = sgn & dividend[DD_W-1];
    // Most-negative inputs negate to themselves, which reads correctly as 2^(W-1) unsigned.
    dv_mag  = neg_dv ? (~divisor) + DV_W'(1) : divisor;
    dd_mag  = neg_dd ? (~dividend) + DD_W'(1) : dividend;
    no_cero = |divisor;
    neg_q   = (neg_dv ^ neg_dd) & no_cero;
    ovf     = no_cero & (dd_mag[DD_W-1:Q_W] >= dv_mag);
    entry   = {dv_mag, dd_mag, neg_dv, neg_dd, neg_q, no_cero, ovf};
  end

endmodule

// File: rtl/reg_en.sv
// Generic enabled register with synchronous active-high clear.
module reg_en #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/etapa1_hs.sv
// First divider stage: registers pre-conditioned operands behind a valid/ready
// handshake with a 2-entry skid buffer (main M drives outputs, skid S absorbs a stall).
//
//   state    | meaning
//   ---------+----------------------------------------------
//   ST_EMPTY | nothing held, ready for upstream
//   ST_ONE   | M valid on outputs, still accepting
//   ST_FULL  | M valid and S holds the next item, not ready
module etapa1_hs
  import etapa1_hs_pkg::*;
#(
  parameter int DV_W = DV_W_DEF,
  parameter int DD_W = DD_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            goIn,
  output logic            readyOut,
  input  logic            signedIn,
  input  logic [DV_W-1:0] divisorIn,
  input  logic [DD_W-1:0] dividendIn,
  output logic            goOut,
  input  logic            readyIn,
  output logic [DV_W-1:0] divisorMagOut,
  output logic [DD_W-1:0] dividendMagOut,
  output logic            negDivisorOut,
  output logic            negDividendOut,
  output logic            negQuotientOut,
  output logic            DivisorNoCeroOut,
  output logic            overflowOut
);

  localparam int EW     = entry_w(DV_W, DD_W);
  localparam int OFF_DV = off_dvmag(DD_W);

  state_t        state;
  logic          go_q;
  logic          ready_q;
  logic          accept;
  logic          deliver;
  logic          load_m;
  logic          load_s;
  logic [EW-1:0] entry_in;
  logic [EW-1:0] m_d;
  logic [EW-1:0] m_q;
  logic [EW-1:0] s_q;

  div_precond #(.DV_W(DV_W), .DD_W(DD_W)) u_precond (
    .sgn      (signedIn),
    .divisor  (divisorIn),
    .dividend (dividendIn),
    .entry    (entry_in)
  );

  assign accept  = goIn & ready_q;
  assign deliver = go_q & readyIn;

  always_comb begin
    load_m = 1'b0;
    load_s = 1'b0;
    m_d    = entry_in;
    case (state)
      ST_EMPTY: load_m = accept;
      ST_ONE: begin
        load_m = accept & deliver;
        load_s = accept & ~deliver;
      end
      ST_FULL: begin
        load_m = deliver;
        m_d    = s_q;
      end
      default: ;
    endcase
  end

  reg_en #(.W(EW)) u_reg_m (
    .clk   (clk),
    .reset (reset),
    .en    (load_m),
    .d     (m_d),
    .q     (m_q)
  );

  reg_en #(.W(EW)) u_reg_s (
    .clk   (clk),
    .reset (reset),
    .en    (load_s),
    .d     (entry_in),
    .q     (s_q)
  );

  // ready_q is held low through reset so the first ready cycle follows the release edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_EMPTY;
      go_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          ready_q <= 1'b1;
          if (accept) begin
            state <= ST_ONE;
            go_q  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !deliver) begin
            state   <= ST_FULL;
            ready_q <= 1'b0;
          end else if (!accept && deliver) begin
            state <= ST_EMPTY;
            go_q  <= 1'b0;
          end
        end
        ST_FULL: begin
          if (deliver) begin
            state   <= ST_ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          go_q    <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign readyOut         = ready_q;
  assign goOut            = go_q;
  assign divisorMagOut    = m_q[OFF_DV +: DV_W];
  assign dividendMagOut   = m_q[OFF_DDMAG +: DD_W];
  assign negDivisorOut    = m_q[OFF_NEGDV];
  assign negDividendOut   = m_q[OFF_NEGDD];
  assign negQuotientOut   = m_q[OFF_NEGQ];
  assign DivisorNoCeroOut = m_q[OFF_NOCERO];
  assign overflowOut      = m_q[OFF_OVF];

endmodule

// File: tb/tb_etapa1_hs.sv
// Directed bench for etapa1_hs at DV_W=16, DD_W=32.
module tb_etapa1_hs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        goIn = 1'b0;
  logic        readyOut;
  logic        signedIn = 1'b0;
  logic [15:0] divisorIn = '0;
  logic [31:0] dividendIn = '0;
  logic        goOut;
  logic        readyIn = 1'b1;
  logic [15:0] divisorMagOut;
  logic [31:0] dividendMagOut;
  logic        negDivisorOut;
  logic        negDividendOut;
  logic        negQuotientOut;
  logic        DivisorNoCeroOut;
  logic        overflowOut;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [52:0] obs;
  logic [31:0] mon_q[$];

  etapa1_hs #(.DV_W(16), .DD_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .goIn             (goIn),
    .readyOut         (readyOut),
    .signedIn         (signedIn),
    .divisorIn        (divisorIn),
    .dividendIn       (dividendIn),
    .goOut            (goOut),
    .readyIn          (readyIn),
    .divisorMagOut    (divisorMagOut),
    .dividendMagOut   (dividendMagOut),
    .negDivisorOut    (negDivisorOut),
    .negDividendOut   (negDividendOut),
    .negQuotientOut   (negQuotientOut),
    .DivisorNoCeroOut (DivisorNoCeroOut),
    .overflowOut      (overflowOut)
  );

  always #5 clk = ~clk;

  assign obs = {divisorMagOut, dividendMagOut, negDivisorOut, negDividendOut,
                negQuotientOut, DivisorNoCeroOut, overflowOut};

  always @(negedge clk) begin
    if (!reset && goOut && readyIn) mon_q.push_back(dividendMagOut);
  end

  task automatic send_item(input logic sgn, input logic [15:0] dv, input logic [31:0] dd);
    @(posedge clk); #1;
    goIn = 1'b1; signedIn = sgn; divisorIn = dv; dividendIn = dd;
    @(posedge clk); #1;
    goIn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; goIn = 1'b1; signedIn = 1'b1;
    divisorIn = 16'h1234; dividendIn = 32'h89AB_CDEF;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (goOut !== 1'b0) $display("FAIL rst_goOut got %b want 0", goOut); else pass_cnt++;
    total_cnt++; if (readyOut !== 1'b0) $display("FAIL rst_readyOut got %b want 0", readyOut); else pass_cnt++;
    total_cnt++; if (obs !== 53'h0) $display("FAIL rst_data got %h want 0", obs); else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (readyOut !== 1'b1) $display("FAIL rel_readyOut got %b want 1", readyOut); else pass_cnt++;
    total_cnt++; if (goOut !== 1'b0) $display("FAIL rel_goOut got %b want 0", goOut); else pass_cnt++;
    goIn = 1'b0;
  endtask

  task automatic test_signed();
    send_item(1'b1, 16'h0007, 32'hFFFF_FF9C);
    total_cnt++; if (goOut !== 1'b1) $display("FAIL signed_goOut got %b want 1", goOut); else pass_cnt++;
    total_cnt++;
    if (obs !== {16'h0007, 32'h0000_0064, 5'b01110})
      $display("FAIL signed_data got %h want %h", obs, {16'h0007, 32'h0000_0064, 5'b01110});
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (goOut !== 1'b0) $display("FAIL signed_drain got %b want 0", goOut); else pass_cnt++;
  endtask

  task automatic test_div_zero_unsigned();
    send_item(1'b1, 16'h0000, 32'hFFFF_0000);
    total_cnt++;
    if (obs !== {16'h0000, 32'h0001_0000, 5'b01000})
      $display("FAIL divzero_data got %h want %h", obs, {16'h0000, 32'h0001_0000, 5'b01000});
    else pass_cnt++;
    send_item(1'b0, 16'h8000, 32'hFFFF_0000);
    total_cnt++;
    if (obs !== {16'h8000, 32'hFFFF_0000, 5'b00011})
      $display("FAIL unsigned_data got %h want %h", obs, {16'h8000, 32'hFFFF_0000, 5'b00011});
    else pass_cnt++;
  endtask

  task automatic test_overflow_boundary();
    send_item(1'b0, 16'h0005, 32'h0005_0000);
    total_cnt++;
    if (obs !== {16'h0005, 32'h0005_0000, 5'b00011})
      $display("FAIL ovf_edge_hi got %h want %h", obs, {16'h0005, 32'h0005_0000, 5'b00011});
    else pass_cnt++;
    send_item(1'b0, 16'h0005, 32'h0004_FFFF);
    total_cnt++;
    if (obs !== {16'h0005, 32'h0004_FFFF, 5'b00010})
      $display("FAIL ovf_edge_lo got %h want %h", obs, {16'h0005, 32'h0004_FFFF, 5'b00010});
    else pass_cnt++;
  endtask

  task automatic test_most_negative();
    send_item(1'b1, 16'hFFFF, 32'h8000_0000);
    total_cnt++;
    if (obs !== {16'h0001, 32'h8000_0000, 5'b11011})
      $display("FAIL mostneg_data got %h want %h", obs, {16'h0001, 32'h8000_0000, 5'b11011});
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_bp [4];
    int base;
    int sent;
    logic acc;
    exp_bp = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
    base = mon_q.size();
    readyIn = 1'b0;
    @(posedge clk); #1;
    goIn = 1'b1; signedIn = 1'b0; divisorIn = 16'h0001; dividendIn = 32'hA1;
    @(posedge clk); #1;
    total_cnt++; if (goOut !== 1'b1) $display("FAIL bp_a_goOut got %b want 1", goOut); else pass_cnt++;
    total_cnt++; if (dividendMagOut !== 32'hA1) $display("FAIL bp_a_data got %h want a1", dividendMagOut); else pass_cnt++;
    dividendIn = 32'hB2;
    @(posedge clk); #1;
    total_cnt++; if (readyOut !== 1'b0) $display("FAIL bp_full_ready got %b want 0", readyOut); else pass_cnt++;
    total_cnt++; if (dividendMagOut !== 32'hA1) $display("FAIL bp_full_data got %h want a1", dividendMagOut); else pass_cnt++;
    dividendIn = 32'hC3;
    @(posedge clk); #1;
    total_cnt++; if (readyOut !== 1'b0) $display("FAIL bp_hold_ready got %b want 0", readyOut); else pass_cnt++;
    total_cnt++; if (dividendMagOut !== 32'hA1) $display("FAIL bp_hold_data got %h want a1", dividendMagOut); else pass_cnt++;
    readyIn = 1'b1;
    sent = 0;
    for (int cyc = 0; cyc < 20 && sent < 2; cyc++) begin
      @(negedge clk);
      acc = goIn && readyOut;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 2) dividendIn = 32'hD4;
        else goIn = 1'b0;
      end
    end
    goIn = 1'b0;
    total_cnt++; if (sent !== 2) $display("FAIL bp_send_timeout got %0d want 2", sent); else pass_cnt++;
    for (int cyc = 0; cyc < 20 && goOut; cyc++) begin
      @(posedge clk); #1;
    end
    total_cnt++; if (goOut !== 1'b0) $display("FAIL bp_drain_timeout got %b want 0", goOut); else pass_cnt++;
    total_cnt++;
    if (mon_q.size() - base !== 4) $display("FAIL bp_count got %0d want 4", mon_q.size() - base);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (base + i >= mon_q.size()) $display("FAIL bp_order[%0d] got none want %h", i, exp_bp[i]);
      else if (mon_q[base+i] !== exp_bp[i]) $display("FAIL bp_order[%0d] got %h want %h", i, mon_q[base+i], exp_bp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = mon_q.size();
    readyIn = 1'b1;
    @(posedge clk); #1;
    goIn = 1'b1; signedIn = 1'b0; divisorIn = 16'h0003; dividendIn = 32'h100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (goOut !== 1'b1 || readyOut !== 1'b1 || dividendMagOut !== 32'h100 + i)
        $display("FAIL b2b_step[%0d] got go=%b rdy=%b data=%h want go=1 rdy=1 data=%h",
                 i, goOut, readyOut, dividendMagOut, 32'h100 + i);
      else pass_cnt++;
      if (i < 4) dividendIn = 32'h100 + i + 1;
      else goIn = 1'b0;
    end
    @(posedge clk); #1;
    total_cnt++; if (goOut !== 1'b0) $display("FAIL b2b_drain got %b want 0", goOut); else pass_cnt++;
    total_cnt++;
    if (mon_q.size() - base !== 5) $display("FAIL b2b_count got %0d want 5", mon_q.size() - base);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (base + i >= mon_q.size()) $display("FAIL b2b_order[%0d] got none want %h", i, 32'h100 + i);
      else if (mon_q[base+i] !== 32'h100 + i) $display("FAIL b2b_order[%0d] got %h want %h", i, mon_q[base+i], 32'h100 + i);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int base;
    readyIn = 1'b0;
    @(posedge clk); #1;
    goIn = 1'b1; signedIn = 1'b1; divisorIn = 16'hFFF0; dividendIn = 32'h0000_0055;
    repeat (2) @(posedge clk);
    #1;
    goIn = 1'b0;
    total_cnt++; if (readyOut !== 1'b0) $display("FAIL mid_full got %b want 0", readyOut); else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (goOut !== 1'b0 || readyOut !== 1'b0 || obs !== 53'h0)
      $display("FAIL mid_rst got go=%b rdy=%b data=%h want 0 0 0", goOut, readyOut, obs);
    else pass_cnt++;
    reset = 1'b0;
    readyIn = 1'b1;
    base = mon_q.size();
    @(posedge clk); #1;
    total_cnt++;
    if (readyOut !== 1'b1 || goOut !== 1'b0)
      $display("FAIL mid_rel got go=%b rdy=%b want go=0 rdy=1", goOut, readyOut);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (mon_q.size() !== base) $display("FAIL mid_discard got %0d deliveries want 0", mon_q.size() - base);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_signed();
    test_div_zero_unsigned();
    test_overflow_boundary();
    test_most_negative();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
